// File: rtl/cosim_ep_arbiter.sv
// Shares one cosim endpoint among NUM_CHANNELS requesters: round-robin tagging toward
// the endpoint DataIn side, ID-based steering of endpoint DataOut messages back to channels.
module cosim_ep_arbiter #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DATA_BITS    = 32,
  parameter int unsigned ID_BITS      = 2
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_CHANNELS-1:0]           ReqValid,
  output logic [NUM_CHANNELS-1:0]           ReqReady,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] ReqData,
  output logic                              EpInValid,
  input  logic                              EpInReady,
  output logic [ID_BITS+DATA_BITS-1:0]      EpInData,
  input  logic                              EpOutValid,
  output logic                              EpOutReady,
  input  logic [ID_BITS+DATA_BITS-1:0]      EpOutData,
  output logic [NUM_CHANNELS-1:0]           RspValid,
  input  logic [NUM_CHANNELS-1:0]           RspReady,
  output logic [DATA_BITS-1:0]              RspData,
  output logic [7:0]                        DropCount
);

  localparam int unsigned MSG_BITS = ID_BITS + DATA_BITS;

  generate
    if ((64'd1 << ID_BITS) < 64'(NUM_CHANNELS)) begin : g_id_bits_check
      $error("cosim_ep_arbiter: ID_BITS=%0d too narrow for NUM_CHANNELS=%0d", ID_BITS, NUM_CHANNELS);
    end
    if (NUM_CHANNELS < 2 || NUM_CHANNELS > 16) begin : g_num_ch_check
      $error("cosim_ep_arbiter: NUM_CHANNELS=%0d outside 2..16", NUM_CHANNELS);
    end
  endgenerate

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} buf_state_e;

  // Reset release synchroniser; assertion stays asynchronous.
  logic [1:0] r_rst_sync;
  logic       w_run;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rst_sync <= 2'b00;
    else       r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_run = r_rst_sync[1];

  // Channel index base+off wrapped modulo NUM_CHANNELS (off in 1..NUM_CHANNELS).
  function automatic logic [ID_BITS-1:0] wrap_add(input logic [ID_BITS-1:0] base,
                                                  input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_CHANNELS) s = s - NUM_CHANNELS;
    return ID_BITS'(s);
  endfunction

  // ---------------- Host-bound path ----------------
  buf_state_e                r_in_state;
  buf_state_e                w_in_state_nxt;
  logic [MSG_BITS-1:0]       r_in_data;
  logic [ID_BITS-1:0]        r_last;
  logic                      w_load;
  logic                      w_grant_vld;
  logic [ID_BITS-1:0]        w_grant_idx;
  logic [NUM_CHANNELS-1:0]   w_grant_oh;
  logic [DATA_BITS-1:0]      w_grant_data;

  // First valid requester searching from last-granted+1.
  always_comb begin
    w_grant_vld  = 1'b0;
    w_grant_idx  = '0;
    w_grant_oh   = '0;
    w_grant_data = '0;
    for (int unsigned k = 1; k <= NUM_CHANNELS; k++) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (!w_grant_vld && ReqValid[i] && (ID_BITS'(i) == wrap_add(r_last, k))) begin
          w_grant_vld   = 1'b1;
          w_grant_idx   = ID_BITS'(i);
          w_grant_oh[i] = 1'b1;
          w_grant_data  = ReqData[i*DATA_BITS +: DATA_BITS];
        end
      end
    end
  end

  always_comb begin
    w_in_state_nxt = r_in_state;
    w_load         = w_run && ((r_in_state == ST_EMPTY) || EpInReady);
    ReqReady       = '0;
    if (w_load) begin
      ReqReady       = w_grant_oh;
      w_in_state_nxt = w_grant_vld ? ST_FULL : ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_in_state <= ST_EMPTY;
      r_in_data  <= '0;
      r_last     <= ID_BITS'(NUM_CHANNELS - 1);
    end else begin
      r_in_state <= w_in_state_nxt;
      if (w_load && w_grant_vld) begin
        r_in_data <= {w_grant_idx, w_grant_data};
        r_last    <= w_grant_idx;
      end
    end
  end

  assign EpInValid = (r_in_state == ST_FULL);
  assign EpInData  = r_in_data;

  // ---------------- Hardware-bound path ----------------
  logic [NUM_CHANNELS-1:0] r_rsp_valid;
  logic [DATA_BITS-1:0]    r_rsp_data;
  logic [7:0]              r_drop_cnt;
  logic [ID_BITS-1:0]      w_out_id;
  logic                    w_id_ok;
  logic [NUM_CHANNELS-1:0] w_out_oh;
  logic                    w_drain;
  logic                    w_accept;

  always_comb begin
    w_out_id = EpOutData[MSG_BITS-1 -: ID_BITS];
    w_id_ok  = (32'(w_out_id) < NUM_CHANNELS);
    w_out_oh = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      w_out_oh[i] = (w_out_id == ID_BITS'(i));
    end
    // Held response drains this cycle: pass-through to a new capture.
    w_drain    = |(r_rsp_valid & RspReady);
    EpOutReady = w_run && ((r_rsp_valid == '0) || w_drain);
    w_accept   = EpOutValid && EpOutReady;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_drop_cnt  <= 8'd0;
    end else begin
      if (w_accept && w_id_ok) begin
        r_rsp_valid <= w_out_oh;
        r_rsp_data  <= EpOutData[DATA_BITS-1:0];
      end else if (w_drain) begin
        r_rsp_valid <= '0;
      end
      if (w_accept && !w_id_ok && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign RspValid  = r_rsp_valid;
  assign RspData   = r_rsp_data;
  assign DropCount = r_drop_cnt;

endmodule
